// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller
//
// Frequency-sweep sequencer for the DDS frequency control word. It steps the
// control word from a start value toward a stop value in fixed increments.
// Each value is held for (dwell + 1) cycles. Three sweep modes are supported:
// single, repeat (sawtooth) and triangle. The final step is clamped to the
// target, so the control word never wraps past 0 or all-ones.
//
// Handshake: io_start and io_abort are single-cycle requests, sampled on the
// rising clock edge. There is no ready signal.
//   - A start is accepted only in IDLE, and only when abort is low.
//   - Abort is honoured in IDLE and DWELL. It always beats start or a dwell
//     expiry in the same cycle.
//   - io_fcwValid pulses on the cycle after every write to io_fcw.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   io_start    sweep start request
//   io_abort    stop the sweep; io_fcw holds its current value
//   io_mode     0 single, 1 repeat, 2 triangle, 3 single
//   io_fStart   first control word
//   io_fStop    final control word
//   io_fStep    step magnitude (0 is treated as 1)
//   io_dwell    hold time per value, in cycles minus 1
//   io_fcw      control word to the DDS
//   io_fcwValid one-cycle pulse after each io_fcw write
//   io_busy     high while sweeping
//   io_done     one-cycle pulse at the end of a single sweep
//   io_state    current FSM state (0 IDLE, 1 DWELL, 2 DONE) for observation
module dds_sweep_controller #(
  parameter int g_accWidth   = 32,
  parameter int g_dwellWidth = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_start,
  input  logic                    io_abort,
  input  logic [1:0]              io_mode,
  input  logic [g_accWidth-1:0]   io_fStart,
  input  logic [g_accWidth-1:0]   io_fStop,
  input  logic [g_accWidth-1:0]   io_fStep,
  input  logic [g_dwellWidth-1:0] io_dwell,
  output logic [g_accWidth-1:0]   io_fcw,
  output logic                    io_fcwValid,
  output logic                    io_busy,
  output logic                    io_done,
  output logic [1:0]              io_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  state_t                  state_q, state_n;
  logic [g_accWidth-1:0]   fcw_q, fcw_n;
  logic                    valid_q, valid_n;
  logic                    busy_q, done_q;
  logic [1:0]              mode_q, mode_n;
  logic [g_accWidth-1:0]   start_q, start_n;
  logic [g_accWidth-1:0]   target_q, target_n;
  logic [g_accWidth-1:0]   step_q, step_n;
  logic [g_dwellWidth-1:0] dwell_q, dwell_n;
  logic [g_dwellWidth-1:0] cnt_q, cnt_n;
  logic                    up_q, up_n;

  // Move one step toward the target. The step is compared against the
  // remaining distance, not against the sum, so no addition or subtraction
  // can overflow.
  function automatic logic [g_accWidth-1:0] step_toward(
    input logic [g_accWidth-1:0] cur,
    input logic [g_accWidth-1:0] tgt,
    input logic [g_accWidth-1:0] stp,
    input logic                  up
  );
    logic [g_accWidth-1:0] diff;
    if (up) begin
      diff = tgt - cur;
      step_toward = (diff <= stp) ? tgt : cur + stp;
    end else begin
      diff = cur - tgt;
      step_toward = (diff <= stp) ? tgt : cur - stp;
    end
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      fcw_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= '0;
      start_q  <= '0;
      target_q <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      up_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      fcw_q    <= fcw_n;
      valid_q  <= valid_n;
      busy_q   <= (state_n == DWELL);
      done_q   <= (state_n == DONE);
      mode_q   <= mode_n;
      start_q  <= start_n;
      target_q <= target_n;
      step_q   <= step_n;
      dwell_q  <= dwell_n;
      cnt_q    <= cnt_n;
      up_q     <= up_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    fcw_n    = fcw_q;
    valid_n  = 1'b0;
    mode_n   = mode_q;
    start_n  = start_q;
    target_n = target_q;
    step_n   = step_q;
    dwell_n  = dwell_q;
    cnt_n    = cnt_q;
    up_n     = up_q;

    case (state_q)
      IDLE: begin
        if (io_start && !io_abort) begin
          mode_n   = io_mode;
          start_n  = io_fStart;
          target_n = io_fStop;
          // A zero step would stall the sweep forever.
          step_n   = (io_fStep == '0) ? g_accWidth'(1) : io_fStep;
          dwell_n  = io_dwell;
          fcw_n    = io_fStart;
          valid_n  = 1'b1;
          cnt_n    = io_dwell;
          up_n     = (io_fStop >= io_fStart);
          state_n  = DWELL;
        end
      end

      DWELL: begin
        if (io_abort) begin
          state_n = IDLE;
        end else if (cnt_q != '0) begin
          cnt_n = cnt_q - g_dwellWidth'(1);
        end else if (fcw_q != target_q) begin
          fcw_n   = step_toward(fcw_q, target_q, step_q, up_q);
          valid_n = 1'b1;
          cnt_n   = dwell_q;
        end else begin
          case (mode_q)
            MODE_REPEAT: begin
              fcw_n   = start_q;
              valid_n = 1'b1;
              cnt_n   = dwell_q;
            end
            MODE_TRIANGLE: begin
              // Reverse the sweep and take the first step of the new leg
              // in the same cycle, so the turning point is not held twice.
              start_n  = target_q;
              target_n = start_q;
              up_n     = !up_q;
              fcw_n    = step_toward(fcw_q, start_q, step_q, !up_q);
              valid_n  = 1'b1;
              cnt_n    = dwell_q;
            end
            default: begin
              state_n = DONE;
            end
          endcase
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign io_fcw      = fcw_q;
  assign io_fcwValid = valid_q;
  assign io_busy     = busy_q;
  assign io_done     = done_q;
  assign io_state    = state_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed testbench for dds_sweep_controller.
//
// Each expected io_fcw value is pushed onto exp_q. Every valid pulse pops one
// value and compares it with io_fcw. Outputs are sampled on the falling edge.
// Inputs change on the falling edge.
module tb_dds_sweep_controller;

  logic        clock;
  logic        reset;
  logic        io_start;
  logic        io_abort;
  logic [1:0]  io_mode;
  logic [31:0] io_fStart;
  logic [31:0] io_fStop;
  logic [31:0] io_fStep;
  logic [15:0] io_dwell;
  logic [31:0] io_fcw;
  logic        io_fcwValid;
  logic        io_busy;
  logic        io_done;
  logic [1:0]  io_state;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  dds_sweep_controller #(.g_accWidth(32), .g_dwellWidth(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_start    (io_start),
    .io_abort    (io_abort),
    .io_mode     (io_mode),
    .io_fStart   (io_fStart),
    .io_fStop    (io_fStop),
    .io_fStep    (io_fStep),
    .io_dwell    (io_dwell),
    .io_fcw      (io_fcw),
    .io_fcwValid (io_fcwValid),
    .io_busy     (io_busy),
    .io_done     (io_done),
    .io_state    (io_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Driver: present the config with a one-cycle start.
  // Returns at the falling edge one cycle after the start edge.
  task automatic start_pulse(input logic [1:0] mode, input logic [31:0] fs,
                             input logic [31:0] fe, input logic [31:0] st,
                             input logic [15:0] dw);
    @(negedge clock);
    io_mode = mode; io_fStart = fs; io_fStop = fe; io_fStep = st; io_dwell = dw;
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
  endtask

  // Single sweep. exp_q is preloaded with n_vals values. If restart_k is
  // nonzero, a conflicting start with a different config is driven at that
  // cycle; it must be ignored.
  task automatic run_single(input string name, input logic [1:0] mode,
                            input logic [31:0] fs, input logic [31:0] fe,
                            input logic [31:0] st, input logic [15:0] dw,
                            input int n_vals, input int restart_k);
    int k, last_k, busy_cnt, done_k, nv;
    k = 1; last_k = 0; busy_cnt = 0; done_k = 0; nv = 0;
    start_pulse(mode, fs, fe, st, dw);
    while (done_k == 0 && k < 300) begin
      if (io_fcwValid) begin
        nv++;
        if (exp_q.size() > 0) check({name, "_fcw"}, io_fcw, exp_q.pop_front());
        if (last_k != 0) check({name, "_hold"}, 32'(k - last_k), 32'(dw) + 32'd1);
        last_k = k;
      end
      if (io_busy) busy_cnt++;
      if (io_done) done_k = k;
      if (restart_k != 0 && k == restart_k) begin
        io_start = 1'b1; io_mode = 2'd2; io_fStart = 32'd500; io_fStop = 32'd0;
        io_fStep = 32'd1; io_dwell = 16'd0;
      end else begin
        io_start = 1'b0;
      end
      @(negedge clock);
      k++;
    end
    io_start = 1'b0;
    check({name, "_valid_cnt"}, 32'(nv), 32'(n_vals));
    check({name, "_done_at"}, 32'(done_k), 32'(n_vals * (int'(dw) + 1) + 1));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(n_vals * (int'(dw) + 1)));
    check({name, "_done_width"}, {31'd0, io_done}, 32'd0);
    check({name, "_idle"}, {30'd0, io_state}, 32'd0);
    check({name, "_fcw_hold"}, io_fcw, fe);
    exp_q.delete();
  endtask

  // Collect valid pulses for ncyc cycles without expecting done.
  task automatic collect(input string name, input int ncyc, input logic [15:0] dw);
    int last_k, done_seen, zero_seen;
    last_k = 0; done_seen = 0; zero_seen = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (io_fcwValid) begin
        if (exp_q.size() > 0) check({name, "_fcw"}, io_fcw, exp_q.pop_front());
        else check({name, "_extra_valid"}, io_fcw, 32'hFFFF_FFFF ^ io_fcw);
        if (last_k != 0) check({name, "_hold"}, 32'(k - last_k), 32'(dw) + 32'd1);
        last_k = k;
      end
      if (io_done) done_seen++;
      @(negedge clock);
    end
    check({name, "_no_done"}, 32'(done_seen), 32'd0);
    check({name, "_all_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int dseen;
    reset = 1'b0; io_start = 1'b0; io_abort = 1'b0; io_mode = '0;
    io_fStart = '0; io_fStop = '0; io_fStep = '0; io_dwell = '0;
    #12;
    check("rst_fcw", io_fcw, 32'd0);
    check("rst_flags", {29'd0, io_fcwValid, io_busy, io_done}, 32'd0);
    check("rst_state", {30'd0, io_state}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Single up
    exp_q = '{32'd100, 32'd110, 32'd120, 32'd130};
    run_single("single_up", 2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 4, 0);

    // Clamp on the last step
    exp_q = '{32'd0, 32'd10, 32'd20, 32'd25};
    run_single("clamp", 2'd0, 32'd0, 32'd25, 32'd10, 16'd0, 4, 0);

    // Down sweep
    exp_q = '{32'd50, 32'd35, 32'd20};
    run_single("down", 2'd0, 32'd50, 32'd20, 32'd15, 16'd0, 3, 0);

    // Zero step is treated as 1
    exp_q = '{32'd5, 32'd6, 32'd7};
    run_single("step0", 2'd0, 32'd5, 32'd7, 32'd0, 16'd0, 3, 0);

    // Equal endpoints, single, mode 3 behaves as single
    exp_q = '{32'd9};
    run_single("equal", 2'd3, 32'd9, 32'd9, 32'd4, 16'd3, 1, 0);

    // A second start while busy is ignored
    exp_q = '{32'd100, 32'd110, 32'd120, 32'd130};
    run_single("restart", 2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 4, 2);

    // Triangle, then abort while the value is 10
    exp_q = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};
    start_pulse(2'd2, 32'd0, 32'd20, 32'd10, 16'd0);
    collect("tri", 7, 16'd0);
    check("tri_pre_abort", io_fcw, 32'd10);
    io_abort = 1'b1;
    @(negedge clock);
    io_abort = 1'b0;
    check("tri_abort_fcw", io_fcw, 32'd10);
    check("tri_abort_flags", {29'd0, io_fcwValid, io_busy, io_done}, 32'd0);
    check("tri_abort_state", {30'd0, io_state}, 32'd0);
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      if (io_done || io_fcwValid || io_busy) dseen++;
      @(negedge clock);
    end
    check("tri_quiet", 32'(dseen), 32'd0);
    check("tri_fcw_kept", io_fcw, 32'd10);

    // Repeat near the top of the range, with no wrap to 0
    exp_q = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
    start_pulse(2'd1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd1);
    collect("rep", 9, 16'd1);
    io_abort = 1'b1;
    @(negedge clock);
    io_abort = 1'b0;
    check("rep_abort_fcw", io_fcw, 32'hFFFF_FFF0);
    check("rep_abort_busy", {31'd0, io_busy}, 32'd0);

    // Start and abort together in IDLE: no sweep
    @(negedge clock);
    io_mode = 2'd0; io_fStart = 32'd77; io_fStop = 32'd88; io_fStep = 32'd1; io_dwell = 16'd0;
    io_start = 1'b1; io_abort = 1'b1;
    @(negedge clock);
    io_start = 1'b0; io_abort = 1'b0;
    check("sa_fcw", io_fcw, 32'hFFFF_FFF0);
    check("sa_flags", {29'd0, io_fcwValid, io_busy, io_done}, 32'd0);
    @(negedge clock);
    check("sa_state", {30'd0, io_state}, 32'd0);

    // Asynchronous reset in the middle of a sweep
    start_pulse(2'd0, 32'd100, 32'd130, 32'd10, 16'd2);
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("amid_rst_fcw", io_fcw, 32'd0);
    check("amid_rst_flags", {29'd0, io_fcwValid, io_busy, io_done}, 32'd0);
    check("amid_rst_state", {30'd0, io_state}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("post_rst_fcw", io_fcw, 32'd0);
    check("post_rst_busy", {31'd0, io_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
